// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_e;

  localparam logic HL_SEL_LO = 1'b0;
  localparam logic HL_SEL_HI = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract-shift (restoring) for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   sreg,
  input  logic [WIDTH-1:0]   opb,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   sreg_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   top_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  assign sum_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (sreg[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  // Partial remainder shifted left by one needs WIDTH+1 bits before the trial subtract.
  assign top_s  = acc[2*WIDTH-1:WIDTH-1];
  assign ge_s   = (top_s >= {1'b0, opb});
  assign diff_s = top_s[WIDTH-1:0] - opb;

  // Select the multiply or divide iteration.
  always_comb begin
    acc_next  = acc;
    sreg_next = {1'b0, sreg[WIDTH-1:1]};
    if (is_div) begin
      acc_next = {(ge_s ? diff_s : top_s[WIDTH-1:0]), acc[WIDTH-2:0], ge_s};
    end else begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle signed/unsigned multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_EARLY_EXIT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  input  logic             hl_we,
  input  logic             hl_sel,
  input  logic [WIDTH-1:0] hl_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  muldiv_state_e      state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r, acc_step_s;
  logic [WIDTH-1:0]   sreg_r, sreg_step_s, opb_r;
  logic               is_div_r, neg_q_r, neg_r_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  muldiv_op_e         op_s;
  logic               is_signed_s, is_div_s, a_neg_s, b_neg_s, div0_s, accept_s, early_exit_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res_hi_s, res_lo_s;

  assign op_s        = muldiv_op_e'(op);
  assign is_signed_s = (op_s == MD_MULT) || (op_s == MD_DIV);
  assign is_div_s    = (op_s == MD_DIV) || (op_s == MD_DIVU);
  assign a_neg_s     = is_signed_s && srca[WIDTH-1];
  assign b_neg_s     = is_signed_s && srcb[WIDTH-1];
  assign a_mag_s     = a_neg_s ? -srca : srca;
  assign b_mag_s     = b_neg_s ? -srcb : srcb;
  // With a zero divisor the restoring loop on the raw dividend yields HI = srca, LO = all ones.
  assign div0_s      = is_div_s && (srcb == {WIDTH{1'b0}});
  assign accept_s    = start && !cancel;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_exit_s = !is_div_r && (sreg_step_s == {WIDTH{1'b0}});
  // Skipped iterations would only have shifted the product right.
  assign prod_s       = acc_r >> cnt_r;
`else
  assign early_exit_s = 1'b0;
  assign prod_s       = acc_r;
`endif

  assign prod_fix_s = neg_q_r ? -prod_s : prod_s;
  assign quo_s      = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
  assign rem_s      = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  assign res_hi_s   = is_div_r ? rem_s : prod_fix_s[2*WIDTH-1:WIDTH];
  assign res_lo_s   = is_div_r ? quo_s : prod_fix_s[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_r),
    .sreg      (sreg_r),
    .opb       (opb_r),
    .is_div    (is_div_r),
    .acc_next  (acc_step_s),
    .sreg_next (sreg_step_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; cancel outranks every other transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (accept_s) state_next_s = MD_RUN;
        else          state_next_s = MD_IDLE;
      end
      MD_RUN: begin
        if (cancel)                                   state_next_s = MD_IDLE;
        else if ((cnt_r == CNT_ONE) || early_exit_s) state_next_s = MD_FIX;
        else                                          state_next_s = MD_RUN;
      end
      MD_FIX:  state_next_s = MD_IDLE;
      default: state_next_s = MD_IDLE;
    endcase
  end

  // Operand capture, iteration datapath, HI/LO registers and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      sreg_r   <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next_s != MD_IDLE);
      case (state_r)
        MD_IDLE: begin
          if (hl_we) begin
            if (hl_sel == HL_SEL_HI) hi_r <= hl_wdata;
            else                     lo_r <= hl_wdata;
          end
          if (accept_s) begin
            acc_r    <= is_div_s ? {{WIDTH{1'b0}}, (div0_s ? srca : a_mag_s)} : {(2*WIDTH){1'b0}};
            sreg_r   <= is_div_s ? {WIDTH{1'b0}} : b_mag_s;
            opb_r    <= is_div_s ? b_mag_s : a_mag_s;
            is_div_r <= is_div_s;
            neg_q_r  <= !div0_s && (a_neg_s ^ b_neg_s);
            neg_r_r  <= !div0_s && a_neg_s;
            cnt_r    <= CNT_INIT;
          end
        end
        MD_RUN: begin
          if (!cancel) begin
            acc_r  <= acc_step_s;
            sreg_r <= sreg_step_s;
            cnt_r  <= cnt_r - CNT_ONE;
          end
        end
        MD_FIX: begin
          if (!cancel) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random ops against an arithmetic reference model.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        cancel;
  logic        hl_we;
  logic        hl_sel;
  logic [31:0] hl_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .cancel   (cancel),
    .hl_we    (hl_we),
    .hl_sel   (hl_sel),
    .hl_wdata (hl_wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the arithmetic definition of each op.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint          sp;
    longint unsigned up;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {eh, el} = up;
      end
      2'd2: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000;
        end else begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int nb;
    exp_latency = 33;
    if (EARLY && (o == 2'd0 || o == 2'd1)) begin
      m  = (o == 2'd0 && b[31]) ? -b : b;
      nb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
      exp_latency = (nb + 1 < 2) ? 2 : nb + 1;
    end
  endfunction

  // mode 0: plain; 1: start + mthi while busy; 2: mtlo in the issuing cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input string tag);
    logic [31:0] eh, el, pre_hi;
    int lat, bc, elat;
    model(o, a, b, eh, el);
    elat   = exp_latency(o, b);
    pre_hi = hi;
    op = o; srca = a; srcb = b; start = 1'b1;
    hl_we = (mode == 2); hl_sel = 1'b0; hl_wdata = 32'h0000_CAFE;
    tick();
    lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bc++;
      if (mode == 2 && lat == 0) check({tag, " mtlo with start"}, lo, 32'h0000_CAFE);
      if (mode == 1 && lat == 2) check({tag, " mthi ignored while busy"}, hi, pre_hi);
      start    = (mode == 1 && lat == 1);
      hl_we    = (mode == 1 && lat == 1);
      hl_sel   = 1'b1;
      hl_wdata = 32'h0000_1234;
      op       = (mode == 1 && lat == 1) ? ~o : o;
      srca     = $urandom;
      srcb     = $urandom;
      tick();
      lat++;
    end
    start = 1'b0; hl_we = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(bc), 32'(elat));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    if (mode == 1) begin
      tick();
      check({tag, " no queued op"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, pre_hi, pre_lo;
    int          elat;
    reset_n = 1'b0; start = 1'b0; op = 2'd0; srca = 32'd0; srcb = 32'd0;
    cancel = 1'b0; hl_we = 1'b0; hl_sel = 1'b0; hl_wdata = 32'd0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset_n = 1'b1;
    tick();

    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, "mult -2x3");
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
    do_op(2'd3, 32'd7, 32'd0, 0, "divu 7/0");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div min/-1");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0, "div -7/0");
    do_op(2'd2, 32'd100, 32'hFFFF_FFF9, 0, "div 100/-7");
    do_op(2'd1, 32'd9, 32'd0, 0, "multu 9x0");
    do_op(2'd1, 32'd9, 32'd3, 0, "multu 9x3");
    do_op(2'd0, 32'd7, 32'hFFFF_FFFB, 0, "mult 7x-5");

    // Cancel mid-run: HI keeps the mthi value and the unit accepts a new op at once.
    hl_we = 1'b1; hl_sel = 1'b1; hl_wdata = 32'h0000_00AA;
    tick();
    hl_we = 1'b0;
    check("mthi idle", hi, 32'h0000_00AA);
    pre_lo = lo;
    op = 2'd1; srca = 32'd5; srcb = 32'h8000_0005; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 32'(busy), 32'd0);
    check("cancel done", 32'(done), 32'd0);
    check("cancel hi", hi, 32'h0000_00AA);
    check("cancel lo", lo, pre_lo);
    do_op(2'd0, 32'd5, 32'd5, 0, "restart after cancel");

    do_op(2'd3, 32'd1000, 32'd3, 1, "divu busy writes");
    hl_we = 1'b1; hl_sel = 1'b1; hl_wdata = 32'h0000_1234;
    pre_lo = lo;
    tick();
    hl_we = 1'b0;
    check("mthi idle 1234", hi, 32'h0000_1234);
    check("mthi leaves lo", lo, pre_lo);
    do_op(2'd2, 32'hFFFF_FC18, 32'd7, 2, "div with mtlo");

    // Cancel while the result is being written.
    pre_hi = hi; pre_lo = lo;
    op = 2'd3; srca = 32'd50; srcb = 32'd6; start = 1'b1;
    elat = exp_latency(2'd3, 32'd6);
    tick();
    start = 1'b0;
    repeat (elat - 1) tick();
    check("fix busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("fix cancel done", 32'(done), 32'd0);
    check("fix cancel busy", 32'(busy), 32'd0);
    check("fix cancel hi", hi, pre_hi);
    check("fix cancel lo", lo, pre_lo);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 0, $sformatf("random %0d", i));
    end

    // Asynchronous reset in the middle of an operation.
    hl_we = 1'b1; hl_sel = 1'b1; hl_wdata = 32'h0000_0055;
    tick();
    hl_we = 1'b0;
    op = 2'd1; srca = 32'd3; srcb = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset hi", hi, 32'd0);
    check("async reset lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post reset idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
